// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter for data_mem between the core and a DMA engine with bounded locked bursts
module data_mem_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_lock,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   localparam int CW = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

   typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_t;

   state_t          state_q, state_d;
   logic            prio_q, prio_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            cpu_sel, dma_sel, arb_prio;
   logic            cpu_rvalid_q, dma_rvalid_q;
   logic [DW-1:0]   cpu_rdata_q, dma_rdata_q;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= ARB;
         prio_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      cpu_sel  = 1'b0;
      dma_sel  = 1'b0;
      state_d  = state_q;
      prio_d   = prio_q;
      cnt_d    = cnt_q;
      arb_prio = prio_q;
      if (state_q == BURST && dma_req && dma_lock) begin
         // A waiting core only breaks the burst once it has reached its length bound.
         if (cpu_req && cnt_q == MAX_C) begin
            cpu_sel = 1'b1;
            prio_d  = 1'b1;
            state_d = ARB;
            cnt_d   = '0;
         end else begin
            dma_sel = 1'b1;
            prio_d  = 1'b0;
            if (cnt_q != MAX_C)
               cnt_d = cnt_q + CW'(1);
         end
      end else begin
         // Leaving a burst falls straight into arbitration with the core favoured.
         arb_prio = (state_q == BURST) ? 1'b0 : prio_q;
         state_d  = ARB;
         cnt_d    = '0;
         prio_d   = arb_prio;
         if (cpu_req && (!dma_req || !arb_prio)) begin
            cpu_sel = 1'b1;
            prio_d  = 1'b1;
         end else if (dma_req) begin
            dma_sel = 1'b1;
            prio_d  = 1'b0;
            if (dma_lock) begin
               state_d = BURST;
               cnt_d   = CW'(1);
            end
         end
      end
   end

   // Grants are combinational, so the async reset must also mask them directly.
   assign cpu_gnt   = cpu_sel & ~reset;
   assign dma_gnt   = dma_sel & ~reset;
   assign cpu_stall = cpu_req & ~cpu_gnt & ~reset;

   assign mem_addr = cpu_gnt ? cpu_addr  : (dma_gnt ? dma_addr  : '0);
   assign mem_din  = cpu_gnt ? cpu_wdata : (dma_gnt ? dma_wdata : '0);
   assign mem_wr   = (cpu_gnt & cpu_we)  | (dma_gnt & dma_we);
   assign mem_rd   = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         cpu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
      end else begin
         cpu_rvalid_q <= cpu_gnt & ~cpu_we;
         dma_rvalid_q <= dma_gnt & ~dma_we;
         if (cpu_gnt && !cpu_we)
            cpu_rdata_q <= mem_dout;
         if (dma_gnt && !dma_we)
            dma_rdata_q <= mem_dout;
      end
   end

   assign cpu_rvalid = cpu_rvalid_q;
   assign dma_rvalid = dma_rvalid_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign dma_rdata  = dma_rdata_q;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Arbitrates the single-port `data_mem` between two requesters: the processor core's load/store path and a DMA/preload engine used for test-vector loading and block copies. The arbiter sequences every memory access, grants one requester per cycle using round-robin priority, and supports locked DMA bursts with a bounded length so the core cannot starve. It sits between the core's memory controls (`out_acc` address, `memWriteValue`, load/store decode) and `data_mem`, and produces `cpu_stall` for the program counter.

## Interface
- `AW`, 8: address width
- `DW`, 8: data width
- `MAX_BURST`, 4: maximum consecutive locked DMA grants while the CPU is waiting (≥1)

- `CLK` in 1: clock, posedge
- `reset` in 1: asynchronous, active-high reset
- `cpu_req` in 1: CPU access request, held until granted
- `cpu_we` in 1: 1 = store, 0 = load
- `cpu_addr` in AW: CPU address
- `cpu_wdata` in DW: CPU store data
- `cpu_gnt` out 1: CPU access performed this cycle
- `cpu_rvalid` out 1: CPU load data valid (one-cycle pulse)
- `cpu_rdata` out DW: registered CPU load data
- `cpu_stall` out 1: `cpu_req & ~cpu_gnt`
- `dma_req` in 1: DMA request, held until granted
- `dma_lock` in 1: request burst ownership
- `dma_we` in 1: 1 = write
- `dma_addr` in AW: DMA address
- `dma_wdata` in DW: DMA write data
- `dma_gnt` out 1: DMA access performed this cycle
- `dma_rvalid` out 1: DMA read data valid (one-cycle pulse)
- `dma_rdata` out DW: registered DMA read data
- `mem_addr` out AW: to `data_mem` DataAddress
- `mem_rd` out 1: to ReadMem
- `mem_wr` out 1: to WriteMem
- `mem_din` out DW: to DataIn
- `mem_dout` in DW: from DataOut (combinational read)

## Operation
- State registers: `prio` (0 = CPU first, 1 = DMA first), `state` ∈ {ARB, BURST}, and `burst_cnt` (width clog2(MAX_BURST)+1).
- Grants are combinational from the requests and the state. At most one of `cpu_gnt` and `dma_gnt` is high.
- ARB state:
  - Only one side requests: that side is granted.
  - Both sides request: the side selected by `prio` is granted.
  - After any grant, `prio` points to the other side.
  - If DMA is granted with `dma_lock=1`: go to BURST with `burst_cnt=1`.
- BURST state:
  - DMA is granted whenever `dma_req & dma_lock` holds, unless `cpu_req=1` and `burst_cnt==MAX_BURST`. In that case the CPU is granted, `prio` becomes 1, and the state returns to ARB.
  - `burst_cnt` increments on each DMA grant and saturates at MAX_BURST.
  - If `cpu_req=0`, the DMA burst continues without a length limit.
  - If `dma_req=0` or `dma_lock=0`: return to ARB in the same cycle and arbitrate as ARB does, with `prio=0`.
- Memory drive:
  - On a grant, the granted side's addr and wdata drive `mem_addr` and `mem_din`.
  - `mem_wr = gnt & we` and `mem_rd = gnt & ~we`.
  - With no grant, all `mem_*` outputs are 0.
- Reads: on a posedge where `X_gnt & ~X_we`, `X_rdata <= mem_dout` and `X_rvalid <= 1`. Otherwise `X_rvalid <= 0` and `X_rdata` holds its value.
- Requesters must hold req/we/addr/wdata stable until granted. A change while ungranted has no effect other than taking the new values.

## Timing
- Reset (async, immediate) clears everything to 0: all outputs, `prio=0`, `state=ARB`, `burst_cnt=0`.
- Grant latency: 0 cycles when uncontended. Under contention, the worst-case CPU wait is MAX_BURST cycles.
- Write latency: memory is updated at the posedge that ends the grant cycle.
- Read latency: `rvalid` and `rdata` are valid in the cycle after the grant.
- Back-to-back grants to the same side: one access per cycle, with no bubble.
- Reset asserted mid-burst:
  - The burst is aborted and no further grants are issued.
  - Any pending `rvalid` is cleared.
  - After reset is released, arbitration restarts with CPU priority.

## Test plan
- After reset: `cpu_req=1, cpu_we=1, cpu_addr=0x10, cpu_wdata=0xA5` → same-cycle `cpu_gnt=1, mem_wr=1, mem_addr=0x10`. A following load from 0x10 → `cpu_rvalid` one cycle later with `cpu_rdata=0xA5`, and `cpu_stall=0` throughout.
- Both sides request unlocked reads continuously for 6 cycles → grants alternate CPU, DMA, CPU, DMA, CPU, DMA, starting with CPU. Each `rvalid` pulses on its own side one cycle after its grant.
- `dma_lock=1` with DMA requesting 8 beats and `cpu_req` asserted at DMA beat 2 (MAX_BURST=4) → DMA granted beats 1–4, CPU granted in cycle 5, DMA resumes in cycle 6. `cpu_stall=1` for exactly cycles 2–4.
- Locked DMA burst of 10 beats with `cpu_req=0` → 10 consecutive `dma_gnt`. The 10th beat drops `dma_lock` → state returns to ARB with `prio=0`.
- Assert `reset` asynchronously mid-burst (beat 3 of 8) between clock edges → all grants, `mem_*` and `rvalid` go to 0 immediately. After release with both sides requesting, the CPU is granted first.
- Single-DMA write burst to addresses 0x00–0x03 with data 0x11–0x44, followed by CPU reads of 0x00–0x03 → returns 0x11, 0x22, 0x33, 0x44.
